// File: rtl/pulse_counter_bcd_disp.sv
// Debounced up/down/clear key counter with a DIGITS-wide BCD count shown on a
// time-multiplexed seven-segment display.

module pulse_counter_bcd_disp_deb #(
    parameter int unsigned DEB_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int unsigned CW = $clog2(DEB_CYCLES);

    logic          s1, s2, acc, seen;
    logic [1:0]    vld;
    logic [CW-1:0] cnt;

    // seen only arms after a genuine released sample, so a key held through
    // reset cannot produce an event until it is released and pressed again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            acc   <= 1'b1;
            seen  <= 1'b0;
            vld   <= '0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            vld   <= {vld[0], 1'b1};
            press <= 1'b0;
            if (vld[1] && s2)
                seen <= 1'b1;
            if (s2 == acc) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                acc   <= s2;
                cnt   <= '0;
                press <= ~s2 & seen;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module pulse_counter_bcd_disp #(
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned DEB_CYCLES = 240000,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned LZB        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_up_n,
    input  logic                  key_dn_n,
    input  logic                  key_clr_n,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     cath,
    output logic [7:0]            led
);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIGITS-1:0] CATH0 = ~DIGITS'(1);

    logic up_ev, dn_ev, clr_ev;

    pulse_counter_bcd_disp_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst), .key_n(key_up_n), .press(up_ev));
    pulse_counter_bcd_disp_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk(clk), .rst(rst), .key_n(key_dn_n), .press(dn_ev));
    pulse_counter_bcd_disp_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst(rst), .key_n(key_clr_n), .press(clr_ev));

    logic [4*DIGITS-1:0] cnt_inc, cnt_dec;
    logic                inc_wrap, dec_wrap;

    always_comb begin
        logic [3:0] d;
        cnt_inc  = '0;
        cnt_dec  = '0;
        inc_wrap = 1'b1;
        dec_wrap = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = count_bcd[4*i +: 4];
            cnt_inc[4*i +: 4] = d;
            cnt_dec[4*i +: 4] = d;
            if (inc_wrap) begin
                if (d == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = d + 4'd1;
                    inc_wrap = 1'b0;
                end
            end
            if (dec_wrap) begin
                if (d == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = d - 4'd1;
                    dec_wrap = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr_ev) begin
                count_bcd <= '0;
            end else if (up_ev && !dn_ev) begin
                count_bcd <= cnt_inc;
                wrap      <= inc_wrap;
            end else if (dn_ev && !up_ev) begin
                count_bcd <= cnt_dec;
                wrap      <= dec_wrap;
            end
        end
    end

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx, idx_nx;
    logic [DIGITS-1:0] cath_nx;

    always_comb begin
        idx_nx = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++)
            cath_nx[i] = (idx_nx != IW'(i));
    end

    // cath and idx move together so the combinational seg stays aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            cath  <= CATH0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx_nx;
            cath  <= cath_nx;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    function automatic logic [7:0] seg_map(input logic [3:0] d);
        case (d)
            4'd0:    seg_map = 8'b11111100;
            4'd1:    seg_map = 8'b01100000;
            4'd2:    seg_map = 8'b11011010;
            4'd3:    seg_map = 8'b11110010;
            4'd4:    seg_map = 8'b01100110;
            4'd5:    seg_map = 8'b10110110;
            4'd6:    seg_map = 8'b10111110;
            4'd7:    seg_map = 8'b11100000;
            4'd8:    seg_map = 8'b11111110;
            4'd9:    seg_map = 8'b11110110;
            default: seg_map = 8'b00000000;
        endcase
    endfunction

    always_comb begin
        logic [3:0] dig;
        logic       blank;
        dig   = '0;
        blank = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                dig   = count_bcd[4*i +: 4];
                blank = (LZB != 0) && (i != 0);
                for (int unsigned j = i; j < DIGITS; j++)
                    if (count_bcd[4*j +: 4] != 4'd0)
                        blank = 1'b0;
            end
        end
        seg = blank ? 8'b00000000 : seg_map(dig);
    end

    generate
        if (DIGITS == 1) begin : g_led_narrow
            assign led = {4'b0000, count_bcd};
        end else begin : g_led_wide
            assign led = count_bcd[7:0];
        end
    endgenerate
endmodule

// File: tb/tb_pulse_counter_bcd_disp.sv
// Directed bench for pulse_counter_bcd_disp: two instances (LZB=0 and LZB=1)
// share the key inputs and are checked against hand-computed values.

module tb_pulse_counter_bcd_disp;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_up_n, key_dn_n, key_clr_n;
    logic [7:0] count, count2;
    logic       wrap, wrap2;
    logic [7:0] seg, seg2;
    logic [1:0] cath, cath2;
    logic [7:0] led, led2;

    int checks = 0;
    int errors = 0;
    int wrap_cnt = 0;

    always #5 clk = ~clk;

    pulse_counter_bcd_disp #(.DIGITS(2), .DEB_CYCLES(4), .SCAN_DIV(4), .LZB(0)) dut (
        .clk(clk), .rst(rst), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .key_clr_n(key_clr_n), .count_bcd(count), .wrap(wrap), .seg(seg),
        .cath(cath), .led(led));

    pulse_counter_bcd_disp #(.DIGITS(2), .DEB_CYCLES(4), .SCAN_DIV(4), .LZB(1)) dut_lzb (
        .clk(clk), .rst(rst), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .key_clr_n(key_clr_n), .count_bcd(count2), .wrap(wrap2), .seg(seg2),
        .cath(cath2), .led(led2));

    always @(negedge clk)
        if (wrap === 1'b1) wrap_cnt++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic c);
        @(posedge clk); #1;
        key_up_n = ~u; key_dn_n = ~d; key_clr_n = ~c;
        repeat (10) @(posedge clk);
        #1;
        key_up_n = 1'b1; key_dn_n = 1'b1; key_clr_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    int         w0;
    logic       got0, got1;
    logic [7:0] d0_lzb, d1_lzb, d1_plain;

    initial begin
        rst = 1'b1; key_up_n = 1'b1; key_dn_n = 1'b1; key_clr_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", count, 8'h00);
        chk("rst_wrap", 8'(wrap), 8'h00);
        chk("rst_cath", 8'(cath), 8'h02);
        chk("rst_seg", seg, 8'b11111100);
        chk("rst_led", led, 8'h00);
        chk("rst_seg_lzb", seg2, 8'b11111100);

        // idle scan: digit index flips every 4 cycles after reset release
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_cath", 8'(cath), ((k / 4) % 2 == 0) ? 8'h02 : 8'h01);
            chk("idle_seg", seg, 8'b11111100);
            chk("idle_seg_lzb", seg2, (cath2 == 2'b01) ? 8'h00 : 8'b11111100);
        end
        chk("idle_count", count, 8'h00);
        chk("idle_wrap_cnt", 8'(wrap_cnt), 8'h00);

        // press latency: count changes on the 7th edge after the key edge
        @(posedge clk); #1 key_up_n = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk((k < 7) ? "lat_before" : "lat_hit", count, (k < 7) ? 8'h00 : 8'h01);
        end
        repeat (13) @(posedge clk);
        #1 key_up_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("long_press_once", count, 8'h01);

        @(posedge clk); #1 key_up_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 key_up_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("glitch_ignored", count, 8'h01);

        press(1'b0, 1'b0, 1'b1);
        chk("clr_to_zero", count, 8'h00);
        w0 = wrap_cnt;
        repeat (99) press(1'b1, 1'b0, 1'b0);
        chk("up_to_99", count, 8'h99);
        chk("led_mirror", led, 8'h99);
        chk("no_wrap_below_99", 8'(wrap_cnt - w0), 8'h00);
        w0 = wrap_cnt;
        press(1'b1, 1'b0, 1'b0);
        chk("up_overflow", count, 8'h00);
        chk("up_overflow_wrap", 8'(wrap_cnt - w0), 8'h01);

        w0 = wrap_cnt;
        press(1'b0, 1'b1, 1'b0);
        chk("dn_underflow", count, 8'h99);
        chk("dn_underflow_wrap", 8'(wrap_cnt - w0), 8'h01);
        w0 = wrap_cnt;
        press(1'b0, 1'b1, 1'b0);
        chk("dn_98", count, 8'h98);
        chk("dn_98_nowrap", 8'(wrap_cnt - w0), 8'h00);
        press(1'b0, 1'b0, 1'b1);
        repeat (10) press(1'b1, 1'b0, 1'b0);
        chk("up_to_10", count, 8'h10);
        press(1'b0, 1'b1, 1'b0);
        chk("dn_borrow", count, 8'h09);

        press(1'b1, 1'b1, 1'b0);
        chk("up_dn_cancel", count, 8'h09);
        w0 = wrap_cnt;
        press(1'b1, 1'b0, 1'b1);
        chk("clr_wins", count, 8'h00);
        chk("clr_no_wrap", 8'(wrap_cnt - w0), 8'h00);

        repeat (5) press(1'b1, 1'b0, 1'b0);
        chk("lzb_count", count2, 8'h05);
        got0 = 1'b0; got1 = 1'b0;
        d0_lzb = 'x; d1_lzb = 'x; d1_plain = 'x;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cath2 == 2'b01) begin got1 = 1'b1; d1_lzb = seg2; end
            if (cath2 == 2'b10) begin got0 = 1'b1; d0_lzb = seg2; end
            if (cath == 2'b01) d1_plain = seg;
        end
        chk("lzb_both_digits_seen", {6'b0, got1, got0}, 8'h03);
        chk("lzb_digit1_blank", d1_lzb, 8'h00);
        chk("lzb_digit0_five", d0_lzb, 8'b10110110);
        chk("plain_digit1_zero", d1_plain, 8'b11111100);

        // reset asserted mid-debounce, released with the key still held
        @(posedge clk); #1 key_up_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("async_rst_count", count, 8'h00);
        chk("async_rst_cath", 8'(cath), 8'h02);
        chk("async_rst_seg", seg, 8'b11111100);
        chk("async_rst_wrap", 8'(wrap), 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("held_through_rst", count, 8'h00);
        @(posedge clk); #1 key_up_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("release_after_rst", count, 8'h00);
        press(1'b1, 1'b0, 1'b0);
        chk("rearmed_press", count, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
